// File: rtl/img_pkg.sv
// Shared definitions for the image stream generator and bmp_image_writer:
// default frame geometry and the generator's state encoding.
package img_pkg;

    localparam int IMG_WIDTH  = 128;
    localparam int IMG_HEIGHT = 128;
    localparam int IMG_DW     = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_HSYNC  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/image_stream_gen.sv
// Reads one frame from a 1-cycle-latency pixel RAM and streams it raster-order
// with frame and line blanking. All control outputs are registered from next_state.
module image_stream_gen
    import img_pkg::*;
#(
    parameter int WIDTH       = IMG_WIDTH,
    parameter int HEIGHT      = IMG_HEIGHT,
    parameter int DW          = IMG_DW,
    parameter int VSYNC_DELAY = 200,
    parameter int HSYNC_DELAY = 160,
    localparam int AW         = $clog2(WIDTH * HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mem_ren,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          vld,
    output logic [DW-1:0] dout,
    output logic          busy,
    output logic          frame_done,
    output state_t        dbg_state
);

    localparam int CW = max3($clog2(VSYNC_DELAY), $clog2(HSYNC_DELAY), $clog2(WIDTH)) + 1;
    localparam int RW = $clog2(HEIGHT) + 1;

    state_t        state, next_state;
    logic [CW-1:0] cnt, cnt_n;
    logic [RW-1:0] row, row_n;
    logic [DW-1:0] dout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            row   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_n;
            row   <= row_n;
        end
    end

    // cnt is reused as the blanking counter and the column counter.
    always_comb begin
        next_state = state;
        cnt_n      = cnt;
        row_n      = row;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                row_n = '0;
                if (start) next_state = ST_VSYNC;
            end
            ST_VSYNC: begin
                if (cnt == CW'(VSYNC_DELAY - 1)) begin
                    cnt_n      = '0;
                    next_state = ST_HSYNC;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_HSYNC: begin
                if (cnt == CW'(HSYNC_DELAY - 1)) begin
                    cnt_n      = '0;
                    next_state = ST_ACTIVE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_ACTIVE: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    cnt_n = '0;
                    if (row == RW'(HEIGHT - 1)) begin
                        next_state = ST_FLUSH;
                    end else begin
                        row_n      = row + RW'(1);
                        next_state = ST_HSYNC;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_FLUSH: next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // The address advances on every active cycle except the very first of the
    // frame, so it stays linear across lines and holds through blanking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ren    <= 1'b0;
            mem_addr   <= '0;
            vld        <= 1'b0;
            dout_q     <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            mem_ren    <= (next_state == ST_ACTIVE);
            busy       <= (next_state != ST_IDLE);
            frame_done <= (next_state == ST_DONE);
            vld        <= mem_ren;
            dout_q     <= dout;
            if (next_state == ST_IDLE) begin
                mem_addr <= '0;
            end else if (next_state == ST_ACTIVE &&
                         (state == ST_ACTIVE || row != '0)) begin
                mem_addr <= mem_addr + AW'(1);
            end
        end
    end

    // Read data arrives in the vld cycle itself; dout_q keeps the last pixel.
    assign dout      = vld ? mem_rdata : dout_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_image_stream_gen.sv
// Directed and randomized frame sequences for image_stream_gen, compared
// cycle-by-cycle against a timing model derived from the frame arithmetic.
module tb_image_stream_gen;
    import img_pkg::*;

    localparam int W       = 4;
    localparam int H       = 2;
    localparam int DW      = 8;
    localparam int VD      = 3;
    localparam int HD      = 2;
    localparam int AW      = $clog2(W * H);
    localparam int FIRST_K = 1 + VD + HD + 1;         // first vld, cycles after start
    localparam int LAST_K  = VD + H * (HD + W) + 2;   // frame_done cycle

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mem_ren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          vld;
    logic [DW-1:0] dout;
    logic          busy;
    logic          frame_done;
    state_t        dbg_state;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_dout = '0;
    bit            chain;

    image_stream_gen #(
        .WIDTH(W), .HEIGHT(H), .DW(DW), .VSYNC_DELAY(VD), .HSYNC_DELAY(HD)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .vld(vld), .dout(dout), .busy(busy), .frame_done(frame_done),
        .dbg_state(dbg_state)
    );

    // ---- clock / RAM model ----
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= DW'(mem_addr) + 8'h10;
    end

    // ---- reference timing model ----
    function automatic bit pix_at(input int k, output int idx);
        int d, r, c;
        idx = 0;
        d = k - FIRST_K;
        if (d < 0) return 1'b0;
        r = d / (HD + W);
        c = d % (HD + W);
        if (r >= H || c >= W) return 1'b0;
        idx = r * W + c;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_vld"}, 32'(vld), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_frame_done"}, 32'(frame_done), 32'(0));
        chk({tag, "_mem_ren"}, 32'(mem_ren), 32'(0));
        chk({tag, "_dout"}, 32'(dout), 32'(last_dout));
    endtask

    // ---- driver tasks ----
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            check_idle("idle");
        end
    endtask

    // One frame checked every cycle from start+1 to start+LAST_K+1 (busy low).
    task automatic run_frame(input bit prestarted, input bit spur, input bit chain_next);
        int  idx, idx_n;
        bit  pv, pr;
        logic [DW-1:0] e;
        exp_q.delete();
        for (int i = 0; i < W * H; i++) exp_q.push_back(DW'(i + 16));
        if (!prestarted) begin
            @(posedge clk);
            #1 start = 1'b1;
        end
        for (int k = 1; k <= LAST_K + 1; k++) begin
            @(posedge clk);
            #1 start = (spur && (k == 5 || k == LAST_K)) || (chain_next && k == LAST_K + 1);
            @(negedge clk);
            pv = pix_at(k, idx);
            pr = pix_at(k + 1, idx_n);
            chk("vld", 32'(vld), 32'(pv));
            chk("busy", 32'(busy), 32'(k <= LAST_K));
            chk("frame_done", 32'(frame_done), 32'(k == LAST_K));
            chk("mem_ren", 32'(mem_ren), 32'(pr));
            if (pr) chk("mem_addr", 32'(mem_addr), 32'(idx_n));
            if (pv) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'(1));
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                last_dout = e;
                chk("dout_pix", 32'(dout), 32'(e));
            end else begin
                chk("dout_hold", 32'(dout), 32'(last_dout));
            end
        end
        chk("sb_drained", 32'(exp_q.size()), 32'(0));
    endtask

    // Starts a frame and asserts reset at the second vld of line 0.
    task automatic reset_mid_line();
        @(posedge clk);
        #1 start = 1'b1;
        for (int k = 1; k <= FIRST_K + 1; k++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
        end
        chk("mid_vld_before", 32'(vld), 32'(1));
        rst = 1'b1;
        #1;
        last_dout = '0;
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_addr", 32'(mem_addr), 32'(0));
        chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_idle("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_cycles(5);
    endtask

    // ---- stimulus ----
    initial begin
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_addr", 32'(mem_addr), 32'(0));
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_idle("rst");
        rst = 1'b0;
        idle_cycles(3);

        run_frame(1'b0, 1'b0, 1'b0);      // basic frame
        idle_cycles(4);
        run_frame(1'b0, 1'b1, 1'b1);      // ignored starts, then back-to-back
        run_frame(1'b1, 1'b0, 1'b0);
        idle_cycles(2);

        reset_mid_line();
        run_frame(1'b0, 1'b0, 1'b0);      // full frame from address 0

        chain = 1'b0;
        for (int n = 0; n < 6; n++) begin
            bit nxt;
            nxt = ($urandom_range(0, 1) == 1);
            if (!chain) idle_cycles($urandom_range(0, 4));
            run_frame(chain, $urandom_range(0, 1) == 1, nxt);
            chain = nxt;
        end
        if (chain) run_frame(1'b1, 1'b0, 1'b0);
        idle_cycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
